// File: rtl/sp_align_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sp_align_ctrl_pkg
// Purpose : Shared definitions for the byte-domain alignment controller:
//           state encodings, the state width and the default comma symbol.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package sp_align_ctrl_pkg;

    localparam int unsigned c_STATE_W = 3;

    localparam logic [7:0] c_COM_SYM_DEFAULT = 8'hBC;

    localparam logic [c_STATE_W-1:0] c_ST_HUNT      = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_LOCK      = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_ACTIVE    = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_SLIP_WAIT = 3'd3;

endpackage
`default_nettype wire

// File: rtl/sp_align_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sp_sat_counter
// Purpose : Saturating up-counter with synchronous clear and a look-ahead
//           "hit" flag that is high in the cycle whose increment makes the
//           count reach MAX.
// Ports   : clk4f  in   clock
//           reset  in   asynchronous, active-low
//           clear  in   restart count from zero (combines with inc -> 1)
//           inc    in   count up by one (holds at MAX)
//           count  out  W-bit current count
//           hit    out  this cycle's increment reaches MAX
// Revision: 1.0 - initial release
// ============================================================================
module sp_sat_counter #(
    parameter int unsigned W   = 4,
    parameter int unsigned MAX = 15
) (
    input  logic         clk4f,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         hit
);

    localparam logic [W-1:0] c_MAX    = W'(MAX);
    localparam logic [W-1:0] c_PENULT = W'(MAX - 1);

    // Value the increment applies to: a clear in the same cycle restarts
    // from zero, so clear+inc loads one.
    logic [W-1:0] w_base;

    always_comb begin
        w_base = clear ? '0 : count;
    end

    assign hit = inc && (w_base == c_PENULT);

    always_ff @(posedge clk4f or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (w_base != c_MAX)) begin
            count <= w_base + W'(1);
        end else begin
            count <= w_base;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sp_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sp_align_ctrl
// Purpose : Byte-domain alignment/link controller behind the deserializer.
//           Hunts for the comma symbol, requests bit-slips when none turns
//           up, declares the lane active after consecutive commas, then
//           forwards non-comma bytes. Falls back to hunting on a long run of
//           invalid input.
// Ports   : clk4f        in   byte clock
//           reset        in   asynchronous, active-low
//           data_in[7:0] in   deserialized byte
//           valid_in     in   data_in qualifier
//           bitslip      out  one-cycle slip request
//           data_out[7:0]out  forwarded byte (registered)
//           valid_out    out  data_out qualifier
//           active       out  lane aligned
//           state_o[2:0] out  current state (debug)
//           slip_count   out  [SP_ALIGN_STATS_EN] saturating slip tally
//           relock_count out  [SP_ALIGN_STATS_EN] saturating link-drop tally
// Options : define SP_ALIGN_STATS_EN to add the two statistics outputs.
// Revision: 1.0 - initial release
// ============================================================================
module sp_align_ctrl
    import sp_align_ctrl_pkg::*;
#(
    parameter logic [7:0]  COM_SYM     = c_COM_SYM_DEFAULT,
    parameter int unsigned COM_LOCK    = 4,
    parameter int unsigned SLIP_WINDOW = 16,
    parameter int unsigned SLIP_WAIT   = 2,
    parameter int unsigned LOSS_LIMIT  = 8
) (
    input  logic                 clk4f,
    input  logic                 reset,
    input  logic [7:0]           data_in,
    input  logic                 valid_in,
    output logic                 bitslip,
    output logic [7:0]           data_out,
    output logic                 valid_out,
    output logic                 active,
    output logic [c_STATE_W-1:0] state_o
`ifdef SP_ALIGN_STATS_EN
    ,
    output logic [7:0]           slip_count,
    output logic [7:0]           relock_count
`endif
);

    localparam int unsigned c_MISS_W = $clog2(SLIP_WINDOW + 1);
    localparam int unsigned c_LOCK_W = $clog2(COM_LOCK + 1);
    localparam int unsigned c_WAIT_W = $clog2(SLIP_WAIT + 1);
    localparam int unsigned c_LOSS_W = $clog2(LOSS_LIMIT + 1);

    logic [c_STATE_W-1:0] r_state;
    logic                 r_bitslip;
    logic [7:0]           r_data_out;
    logic                 r_valid_out;
    logic                 r_active;

    logic w_is_com;
    logic w_is_data;

    logic w_miss_clr, w_miss_inc, w_miss_hit;
    logic w_lock_clr, w_lock_inc, w_lock_hit;
    logic w_wait_clr, w_wait_inc, w_wait_hit;
    logic w_loss_clr, w_loss_inc, w_loss_hit;

    logic [c_MISS_W-1:0] w_miss_cnt;
    logic [c_LOCK_W-1:0] w_lock_cnt;
    logic [c_WAIT_W-1:0] w_wait_cnt;
    logic [c_LOSS_W-1:0] w_loss_cnt;

    assign w_is_com  = valid_in && (data_in == COM_SYM);
    assign w_is_data = valid_in && (data_in != COM_SYM);

    // Counter control. Each counter is held at zero outside the state that
    // owns it, so a counter that just hit its limit is zeroed on the very
    // next cycle without feeding the hit back into its own clear.
    always_comb begin
        w_miss_clr = 1'b1;
        w_miss_inc = 1'b0;
        w_lock_clr = 1'b1;
        w_lock_inc = 1'b0;
        w_wait_clr = 1'b1;
        w_wait_inc = 1'b0;
        w_loss_clr = 1'b1;
        w_loss_inc = 1'b0;
        case (r_state)
            c_ST_HUNT: begin
                w_miss_clr = w_is_com;
                w_miss_inc = w_is_data;
                w_lock_inc = w_is_com;
            end
            c_ST_LOCK: begin
                // A non-comma here aborts the lock and is itself the first miss.
                w_miss_inc = w_is_data;
                w_lock_clr = w_is_data;
                w_lock_inc = w_is_com;
            end
            c_ST_SLIP_WAIT: begin
                w_wait_clr = 1'b0;
                w_wait_inc = 1'b1;
            end
            c_ST_ACTIVE: begin
                w_loss_clr = valid_in;
                w_loss_inc = !valid_in;
            end
            default: begin
            end
        endcase
    end

    sp_sat_counter #(.W(c_MISS_W), .MAX(SLIP_WINDOW)) u_miss_cnt (
        .clk4f (clk4f),
        .reset (reset),
        .clear (w_miss_clr),
        .inc   (w_miss_inc),
        .count (w_miss_cnt),
        .hit   (w_miss_hit)
    );

    sp_sat_counter #(.W(c_LOCK_W), .MAX(COM_LOCK)) u_lock_cnt (
        .clk4f (clk4f),
        .reset (reset),
        .clear (w_lock_clr),
        .inc   (w_lock_inc),
        .count (w_lock_cnt),
        .hit   (w_lock_hit)
    );

    sp_sat_counter #(.W(c_WAIT_W), .MAX(SLIP_WAIT)) u_wait_cnt (
        .clk4f (clk4f),
        .reset (reset),
        .clear (w_wait_clr),
        .inc   (w_wait_inc),
        .count (w_wait_cnt),
        .hit   (w_wait_hit)
    );

    sp_sat_counter #(.W(c_LOSS_W), .MAX(LOSS_LIMIT)) u_loss_cnt (
        .clk4f (clk4f),
        .reset (reset),
        .clear (w_loss_clr),
        .inc   (w_loss_inc),
        .count (w_loss_cnt),
        .hit   (w_loss_hit)
    );

    // Counts are only consulted through their hit flags; they are kept as
    // named nets so they remain visible when probing the design.
    logic w_unused_counts;
    assign w_unused_counts = ^{w_miss_cnt, w_lock_cnt, w_wait_cnt, w_loss_cnt};

    // Hit flags only fire in their owning states (inc is gated above), so
    // each one doubles as the transition condition for that state.
    always_ff @(posedge clk4f or negedge reset) begin
        if (!reset) begin
            r_state     <= c_ST_HUNT;
            r_bitslip   <= 1'b0;
            r_data_out  <= 8'h00;
            r_valid_out <= 1'b0;
            r_active    <= 1'b0;
        end else begin
            r_bitslip   <= 1'b0;
            r_valid_out <= 1'b0;
            case (r_state)
                c_ST_HUNT, c_ST_LOCK: begin
                    if (w_lock_hit) begin
                        r_state  <= c_ST_ACTIVE;
                        r_active <= 1'b1;
                    end else if (w_miss_hit) begin
                        r_state   <= c_ST_SLIP_WAIT;
                        r_bitslip <= 1'b1;
                    end else if (w_is_com) begin
                        r_state <= c_ST_LOCK;
                    end else if (w_is_data) begin
                        r_state <= c_ST_HUNT;
                    end
                end
                c_ST_SLIP_WAIT: begin
                    if (w_wait_hit) begin
                        r_state <= c_ST_HUNT;
                    end
                end
                c_ST_ACTIVE: begin
                    r_data_out <= data_in;
                    if (w_loss_hit) begin
                        r_state  <= c_ST_HUNT;
                        r_active <= 1'b0;
                    end else begin
                        r_valid_out <= w_is_data;
                    end
                end
                default: begin
                    r_state  <= c_ST_HUNT;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign bitslip   = r_bitslip;
    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign active    = r_active;
    assign state_o   = r_state;

`ifdef SP_ALIGN_STATS_EN
    logic w_slip_stat_hit_unused;
    logic w_relock_stat_hit_unused;

    // The slip tally advances on the same edge that raises bitslip; the
    // relock tally on the edge that leaves ACTIVE.
    sp_sat_counter #(.W(8), .MAX(255)) u_slip_stats (
        .clk4f (clk4f),
        .reset (reset),
        .clear (1'b0),
        .inc   (w_miss_hit),
        .count (slip_count),
        .hit   (w_slip_stat_hit_unused)
    );

    sp_sat_counter #(.W(8), .MAX(255)) u_relock_stats (
        .clk4f (clk4f),
        .reset (reset),
        .clear (1'b0),
        .inc   (w_loss_hit),
        .count (relock_count),
        .hit   (w_relock_stat_hit_unused)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_sp_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_sp_align_ctrl
// Purpose : Self-checking bench for sp_align_ctrl with a behavioural model
//           compared every cycle plus directed literal expectations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sp_align_ctrl;

    localparam logic [7:0] c_COM         = 8'hBC;
    localparam int         c_COM_LOCK    = 4;
    localparam int         c_SLIP_WINDOW = 16;
    localparam int         c_SLIP_WAIT   = 2;
    localparam int         c_LOSS_LIMIT  = 8;

    logic       clk4f    = 1'b0;
    logic       reset    = 1'b0;
    logic [7:0] data_in  = 8'h00;
    logic       valid_in = 1'b0;

    logic       bitslip;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic [2:0] state_o;
`ifdef SP_ALIGN_STATS_EN
    logic [7:0] slip_count;
    logic [7:0] relock_count;
`endif

    int total = 0;
    int bad   = 0;

    sp_align_ctrl dut (
        .clk4f     (clk4f),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .bitslip   (bitslip),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active),
        .state_o   (state_o)
`ifdef SP_ALIGN_STATS_EN
        ,
        .slip_count   (slip_count),
        .relock_count (relock_count)
`endif
    );

    always #5 clk4f = ~clk4f;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 hunting, 1 collecting commas, 2 link up, 3 post-slip quiet time
    int m_mode = 0, m_miss = 0, m_lock = 0, m_wait = 0, m_loss = 0;
    int e_bitslip = 0, e_data = 0, e_vout = 0, e_active = 0;
    int e_slips = 0, e_relocks = 0;

    task automatic model_reset();
        m_mode = 0; m_miss = 0; m_lock = 0; m_wait = 0; m_loss = 0;
        e_bitslip = 0; e_data = 0; e_vout = 0; e_active = 0;
        e_slips = 0; e_relocks = 0;
    endtask

    task automatic model_slip_if_due();
        if (m_miss == c_SLIP_WINDOW) begin
            m_miss = 0;
            m_wait = 0;
            m_mode = 3;
            e_bitslip = 1;
            if (e_slips < 255) e_slips++;
        end
    endtask

    task automatic model_edge();
        bit com;
        com = (data_in == c_COM);
        e_bitslip = 0;
        e_vout = 0;
        case (m_mode)
            0: if (valid_in) begin
                if (com) begin
                    m_miss = 0;
                    m_lock = 1;
                    m_mode = (m_lock == c_COM_LOCK) ? 2 : 1;
                end else begin
                    m_miss++;
                    model_slip_if_due();
                end
            end
            1: if (valid_in) begin
                if (com) begin
                    m_lock++;
                    if (m_lock == c_COM_LOCK) m_mode = 2;
                end else begin
                    m_lock = 0;
                    m_miss = 1;
                    m_mode = 0;
                    model_slip_if_due();
                end
            end
            3: begin
                m_wait++;
                if (m_wait == c_SLIP_WAIT) m_mode = 0;
            end
            default: begin
                e_data = int'(data_in);
                if (valid_in) begin
                    m_loss = 0;
                    e_vout = com ? 0 : 1;
                end else begin
                    m_loss++;
                    if (m_loss == c_LOSS_LIMIT) begin
                        m_loss = 0;
                        m_mode = 0;
                        if (e_relocks < 255) e_relocks++;
                    end
                end
            end
        endcase
        e_active = (m_mode == 2) ? 1 : 0;
    endtask

    always @(negedge reset) model_reset();

    always @(posedge clk4f) begin
        if (reset) model_edge();
        #1;
        chk("cyc_bitslip",   32'(bitslip),   e_bitslip);
        chk("cyc_valid_out", 32'(valid_out), e_vout);
        chk("cyc_active",    32'(active),    e_active);
        chk("cyc_state",     32'(state_o),   m_mode);
        chk("cyc_data_out",  32'(data_out),  e_data);
`ifdef SP_ALIGN_STATS_EN
        chk("cyc_slip_count",   32'(slip_count),   e_slips);
        chk("cyc_relock_count", 32'(relock_count), e_relocks);
`endif
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input logic v, input logic [7:0] d);
        valid_in = v;
        data_in  = d;
        @(posedge clk4f);
        #2;
        @(negedge clk4f);
    endtask

    initial begin
        @(negedge clk4f);
        @(negedge clk4f);
        chk("rst_active",    32'(active),    0);
        chk("rst_valid_out", 32'(valid_out), 0);
        chk("rst_bitslip",   32'(bitslip),   0);
        chk("rst_state",     32'(state_o),   0);
        chk("rst_data_out",  32'(data_out),  0);
        reset = 1'b1;

        // Four commas then two data bytes
        for (int i = 0; i < 4; i++) begin
            step(1'b1, c_COM);
            if (i == 2) chk("lock_not_yet_active", 32'(active), 0);
        end
        chk("lock_active", 32'(active), 1);
        chk("lock_state",  32'(state_o), 2);
        chk("lock_no_fwd", 32'(valid_out), 0);
        step(1'b1, 8'h11);
        chk("fwd11_valid", 32'(valid_out), 1);
        chk("fwd11_data",  32'(data_out), 32'h11);
        step(1'b1, 8'h22);
        chk("fwd22_data",  32'(data_out), 32'h22);

        // Commas in the active stream are dropped
        step(1'b1, c_COM);
        chk("act_com_valid", 32'(valid_out), 0);
        step(1'b1, 8'h33);
        chk("act_33_valid", 32'(valid_out), 1);
        chk("act_33_data",  32'(data_out), 32'h33);
        step(1'b1, c_COM);
        chk("act_com2_valid", 32'(valid_out), 0);
        chk("act_com2_active", 32'(active), 1);

        // Loss of input: 7 tolerated, reset by one valid byte, 8 drop the link
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00);
        chk("loss7_active", 32'(active), 1);
        step(1'b1, 8'h44);
        chk("loss_break_data", 32'(data_out), 32'h44);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00);
        chk("loss7b_active", 32'(active), 1);
        step(1'b0, 8'h00);
        chk("loss8_active", 32'(active), 0);
        chk("loss8_state",  32'(state_o), 0);
        chk("loss8_valid",  32'(valid_out), 0);
`ifdef SP_ALIGN_STATS_EN
        chk("relock_count_1", 32'(relock_count), 1);
`endif

        // Sixteen non-commas force one slip; the next two bytes are ignored
        for (int i = 0; i < 15; i++) step(1'b1, 8'h5A);
        chk("slip15_none", 32'(bitslip), 0);
        step(1'b1, 8'h5A);
        chk("slip16_pulse", 32'(bitslip), 1);
        chk("slip16_state", 32'(state_o), 3);
        step(1'b1, c_COM);
        chk("slipw1_pulse_gone", 32'(bitslip), 0);
        chk("slipw1_state", 32'(state_o), 3);
        step(1'b1, c_COM);
        chk("slipw2_hunt", 32'(state_o), 0);
`ifdef SP_ALIGN_STATS_EN
        chk("slip_count_1", 32'(slip_count), 1);
`endif

        // Broken comma run falls back to hunting, a full run then locks
        step(1'b1, c_COM);
        step(1'b1, c_COM);
        step(1'b1, c_COM);
        chk("broken_lockstate", 32'(state_o), 1);
        step(1'b1, 8'h7E);
        chk("broken_state",  32'(state_o), 0);
        chk("broken_active", 32'(active), 0);
        for (int i = 0; i < 4; i++) step(1'b1, c_COM);
        chk("relock_active", 32'(active), 1);

        // Asynchronous reset in the middle of traffic
        step(1'b1, 8'h66);
        chk("pre_rst_valid", 32'(valid_out), 1);
        #3 reset = 1'b0;
        #1;
        chk("arst_active",  32'(active), 0);
        chk("arst_valid",   32'(valid_out), 0);
        chk("arst_bitslip", 32'(bitslip), 0);
        chk("arst_state",   32'(state_o), 0);
        @(negedge clk4f);
        reset = 1'b1;

        // A lock abort seeds the miss count: 1 + 15 more non-commas slip
        step(1'b1, c_COM);
        chk("seed_lock", 32'(state_o), 1);
        step(1'b1, 8'h5A);
        for (int i = 0; i < 14; i++) step(1'b1, 8'h5A);
        chk("seed_15_none", 32'(bitslip), 0);
        step(1'b1, 8'h5A);
        chk("seed_16_pulse", 32'(bitslip), 1);
        #3 reset = 1'b0;
        #1;
        chk("arst_slip_cleared", 32'(bitslip), 0);
        @(negedge clk4f);
        reset = 1'b1;
        step(1'b0, 8'h00);
        chk("post_rst_no_pulse", 32'(bitslip), 0);
        chk("post_rst_state",    32'(state_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
